// File: rtl/fifo_nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// The PARITY state exists only when FIFO_TX_PARITY_EN is defined.
package fifo_tx_pkg;

    localparam int DATA_WIDTH    = 4;
    localparam int BIT_CNT_WIDTH = 2;

`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/fifo_nibble_tx_if.sv
// FIFO read port and serial-side signals of the nibble transmitter.
// master is the transmitter; slave is the FIFO plus line environment.
interface fifo_nibble_tx_if;
    import fifo_tx_pkg::*;

    logic                  tx_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  tx_line;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  tx_en, fifo_empty, fifo_rd_data,
        output fifo_rd_en, tx_line, busy, frame_done
    );

    modport slave (
        output tx_en, fifo_empty, fifo_rd_data,
        input  fifo_rd_en, tx_line, busy, frame_done
    );

endinterface

// File: rtl/fifo_nibble_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of every bit period with bit_tick.
module baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_WIDTH = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST_CNT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bit_tick = enable && !clear && (cnt == LAST_CNT);

endmodule

// File: rtl/fifo_nibble_tx.sv
// Drains a show-ahead nibble FIFO onto a serial line: start bit, 4 data bits LSB first,
// even parity when FIFO_TX_PARITY_EN is defined, then STOP_BITS stop bits.
module fifo_nibble_tx
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rstN,
    fifo_nibble_tx_if.master bus
);

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_STOP_BIT = BIT_CNT_WIDTH'(STOP_BITS - 1);

    tx_state_t                state_q;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q;
    logic                     tx_line_q;
    logic                     busy_q;
    logic                     bit_tick;
    logic                     stop_end;
    logic                     pop;
`ifdef FIFO_TX_PARITY_EN
    logic                     parity_q;
`endif

    // The timer idles at zero in IDLE; every other state ends on a tick, so it is
    // already back at zero whenever the state changes.
    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rstN    (rstN),
        .clear   (state_q == IDLE),
        .enable  (state_q != IDLE),
        .bit_tick(bit_tick)
    );

    assign stop_end = (state_q == STOP) && bit_tick && (bit_cnt_q == LAST_STOP_BIT);

    // Popping is only legal from IDLE or the final stop cycle, and never during reset.
    assign pop = rstN && bus.tx_en && !bus.fifo_empty && ((state_q == IDLE) || stop_end);

    assign bus.fifo_rd_en = pop;
    assign bus.frame_done = stop_end;
    assign bus.tx_line    = tx_line_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_line_q <= 1'b1;
            busy_q    <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q   <= bus.fifo_rd_data;
`ifdef FIFO_TX_PARITY_EN
                        parity_q  <= ^bus.fifo_rd_data;
`endif
                        tx_line_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_line_q <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            bit_cnt_q <= '0;
`ifdef FIFO_TX_PARITY_EN
                            tx_line_q <= parity_q;
                            state_q   <= PARITY;
`else
                            tx_line_q <= 1'b1;
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_line_q <= shift_q[1];
                        end
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        tx_line_q <= 1'b1;
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        if (stop_end) begin
                            bit_cnt_q <= '0;
                            // A pop here chains the next start bit with no idle gap.
                            if (pop) begin
                                shift_q   <= bus.fifo_rd_data;
`ifdef FIFO_TX_PARITY_EN
                                parity_q  <= ^bus.fifo_rd_data;
`endif
                                tx_line_q <= 1'b0;
                                state_q   <= START;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    tx_line_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Bench for fifo_nibble_tx: a FIFO model feeds words, a scoreboard queue holds expected words,
// and a monitor checks every line level of each frame. Follows FIFO_TX_PARITY_EN when defined.
module tb_fifo_nibble_tx;
    import fifo_tx_pkg::*;

    localparam int CPB       = 4;
    localparam int STOP_BITS = 1;
`ifdef FIFO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = (6 + STOP_BITS - 1 + PAR) * CPB;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    fifo_nibble_tx_if bus ();

    fifo_nibble_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         compared    = 0;
    int         mismatched  = 0;
    int         cyc         = 0;
    int         frame_count = 0;
    int         last_done_cyc = 0;
    int         pos         = -1;
    int         pop_cycles[$];
    logic [3:0] exp_q[$];
    logic [3:0] fifo_mem[16];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;
    logic [3:0] cur_word = '0;
    logic [3:0] rx_word  = '0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en === 1'b1 && !bus.fifo_empty) rd_ptr <= rd_ptr + 1'b1;
    end

    function automatic logic expected_level(input logic [3:0] w, input int k);
        int b;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 4) return w[2'(b - 1)];
        if (PAR == 1 && b == 5) return ^w;
        return 1'b1;
    endfunction

    // Frame monitor: follows each pop cycle by cycle and checks line, busy and frame_done.
    always @(negedge clk) begin
        logic exp_bit;
        if (!rstN) begin
            pos = -1;
        end else begin
            if (pos >= 0) begin
                pos++;
                exp_bit = expected_level(cur_word, pos);
                compared++;
                if (bus.tx_line !== exp_bit) begin
                    mismatched++;
                    $display("[TB] FAIL tx_line word=%h frame cycle %0d: got %b, want %b", cur_word, pos, bus.tx_line, exp_bit);
                end
                compared++;
                if (bus.busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL busy_in_frame frame cycle %0d: got %b, want 1", pos, bus.busy);
                end
                compared++;
                if (bus.frame_done !== (pos == FRAME_LEN)) begin
                    mismatched++;
                    $display("[TB] FAIL frame_done frame cycle %0d: got %b, want %b", pos, bus.frame_done, pos == FRAME_LEN);
                end
                if (pos % CPB == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 4)
                    rx_word[2'(pos / CPB - 1)] = bus.tx_line;
                if (pos == FRAME_LEN) begin
                    compared++;
                    if (rx_word !== cur_word) begin
                        mismatched++;
                        $display("[TB] FAIL frame_word: got %h, want %h", rx_word, cur_word);
                    end
                    frame_count++;
                    last_done_cyc = cyc;
                    pos = -1;
                end
            end else begin
                compared++;
                if (bus.frame_done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL frame_done_idle at cycle %0d: got %b, want 0", cyc, bus.frame_done);
                end
            end
            if (bus.fifo_rd_en === 1'b1) begin
                compared++;
                if (pos != -1 || bus.fifo_empty !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL pop_legal at cycle %0d: frame cycle %0d empty %b, want no frame and not empty", cyc, pos, bus.fifo_empty);
                end
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_pop at cycle %0d: got pop, want none", cyc);
                    cur_word = 4'h0;
                end else begin
                    cur_word = exp_q.pop_front();
                end
                pos = 0;
                pop_cycles.push_back(cyc);
            end
        end
    end

    task automatic push_word(input logic [3:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1'b1;
        exp_q.push_back(w);
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (frame_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (frame_count >= target);
    endtask

    task automatic test_reset();
        int p0;
        bus.tx_en = 1'b1;
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.tx_line !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.frame_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got line=%b busy=%b rd_en=%b done=%b, want 1 0 0 0", bus.tx_line, bus.busy, bus.fifo_rd_en, bus.frame_done);
        end
        compared++;
        if (dut.state_q !== IDLE) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d, want IDLE", dut.state_q);
        end
        rstN = 1'b1;
        p0 = pop_cycles.size();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            compared++;
            if (bus.tx_line !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_empty cycle %0d: got line=%b busy=%b rd_en=%b, want 1 0 0", i, bus.tx_line, bus.busy, bus.fifo_rd_en);
            end
        end
        compared++;
        if (pop_cycles.size() != p0) begin
            mismatched++;
            $display("[TB] FAIL idle_no_pop: got %0d pops, want 0", pop_cycles.size() - p0);
        end
    endtask

    task automatic test_single_word();
        int p0, f0;
        bit ok;
        p0 = pop_cycles.size();
        f0 = frame_count;
        push_word(4'hA);
        wait_frames(f0 + 1, FRAME_LEN + 20, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL single_timeout: got %0d frames, want %0d", frame_count - f0, 1);
        end
        compared++;
        if (pop_cycles.size() - p0 != 1) begin
            mismatched++;
            $display("[TB] FAIL single_pops: got %0d, want 1", pop_cycles.size() - p0);
        end
        compared++;
        if (last_done_cyc - pop_cycles[$] != FRAME_LEN) begin
            mismatched++;
            $display("[TB] FAIL single_length: got %0d cycles, want %0d", last_done_cyc - pop_cycles[$], FRAME_LEN);
        end
        @(posedge clk); #1;
        compared++;
        if (bus.busy !== 1'b0 || bus.tx_line !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_idle: got busy=%b line=%b, want 0 1", bus.busy, bus.tx_line);
        end
    endtask

    task automatic run_burst(input string name, input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2, input int count);
        int p0, f0;
        bit ok;
        bus.tx_en = 1'b0;
        @(posedge clk); #1;
        push_word(w0);
        push_word(w1);
        if (count > 2) push_word(w2);
        p0 = pop_cycles.size();
        f0 = frame_count;
        bus.tx_en = 1'b1;
        wait_frames(f0 + count, count * FRAME_LEN + 20, ok);
        compared++;
        if (!ok || pop_cycles.size() - p0 != count) begin
            mismatched++;
            $display("[TB] FAIL %s_count: got %0d pops %0d frames, want %0d", name, pop_cycles.size() - p0, frame_count - f0, count);
        end
        for (int i = 1; i < count && p0 + i < pop_cycles.size(); i++) begin
            compared++;
            if (pop_cycles[p0 + i] - pop_cycles[p0 + i - 1] != FRAME_LEN) begin
                mismatched++;
                $display("[TB] FAIL %s_gap %0d: got %0d cycles, want %0d", name, i, pop_cycles[p0 + i] - pop_cycles[p0 + i - 1], FRAME_LEN);
            end
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s_drain: got %0d words left, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        run_burst("b2b", 4'h1, 4'hF, 4'h6, 3);
    endtask

    task automatic test_parity_words();
        run_burst("parity", 4'h7, 4'h3, 4'h0, 2);
    endtask

    task automatic test_reset_mid_frame();
        int p0, p1, f0, target, n;
        bit ok;
        bus.tx_en = 1'b1;
        p0 = pop_cycles.size();
        f0 = frame_count;
        push_word(4'h9);
        push_word(4'h5);
        n = 0;
        while (pop_cycles.size() == p0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (pop_cycles.size() == p0) begin
            mismatched++;
            $display("[TB] FAIL rst_first_pop: got none, want 1");
        end else begin
            target = pop_cycles[$] + 14;
            n = 0;
            while (cyc < target && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
        end
        compared++;
        if (bus.tx_line !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_data_bit2: got %b, want 0", bus.tx_line);
        end
        rstN = 1'b0;
        #1;
        compared++;
        if (bus.tx_line !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_async: got line=%b busy=%b rd_en=%b, want 1 0 0", bus.tx_line, bus.busy, bus.fifo_rd_en);
        end
        p1 = pop_cycles.size();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (pop_cycles.size() != p1 || bus.fifo_rd_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_no_pop: got %0d pops rd_en=%b, want 0 0", pop_cycles.size() - p1, bus.fifo_rd_en);
        end
        rstN = 1'b1;
        wait_frames(frame_count + 1, FRAME_LEN + 20, ok);
        compared++;
        if (!ok || frame_count - f0 != 1) begin
            mismatched++;
            $display("[TB] FAIL rst_resume: got %0d frames, want 1", frame_count - f0);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL rst_drain: got %0d words left, want 0", exp_q.size());
        end
    endtask

    task automatic test_tx_en_drop();
        int p0, f0;
        bit ok;
        bus.tx_en = 1'b0;
        @(posedge clk); #1;
        push_word(4'hC);
        push_word(4'h2);
        push_word(4'h4);
        p0 = pop_cycles.size();
        f0 = frame_count;
        bus.tx_en = 1'b1;
        @(posedge clk); #1;
        bus.tx_en = 1'b0;
        wait_frames(f0 + 1, FRAME_LEN + 20, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL drop_timeout: got %0d frames, want 1", frame_count - f0);
        end
        repeat (30) @(posedge clk);
        #1;
        compared++;
        if (pop_cycles.size() - p0 != 1) begin
            mismatched++;
            $display("[TB] FAIL drop_pops: got %0d, want 1", pop_cycles.size() - p0);
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.tx_line !== 1'b1 || dut.state_q !== IDLE) begin
            mismatched++;
            $display("[TB] FAIL drop_idle: got busy=%b line=%b state=%0d, want 0 1 IDLE", bus.busy, bus.tx_line, dut.state_q);
        end
        compared++;
        if (4'(wr_ptr - rd_ptr) != 4'd2) begin
            mismatched++;
            $display("[TB] FAIL drop_fill: got %0d words queued, want 2", 4'(wr_ptr - rd_ptr));
        end
        bus.tx_en = 1'b1;
        #1;
        compared++;
        if (bus.fifo_rd_en !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drop_reenable: got rd_en=%b, want 1", bus.fifo_rd_en);
        end
        wait_frames(f0 + 3, 2 * FRAME_LEN + 20, ok);
        compared++;
        if (!ok || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drop_finish: got %0d frames %0d left, want 3 0", frame_count - f0, exp_q.size());
        end
    endtask

    initial begin
        bus.tx_en = 1'b0;
        $display("[TB] frame length %0d cycles", FRAME_LEN);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_parity_words();
        test_reset_mid_frame();
        test_tx_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
